mem_access_unit: RTL and testbench

MEM-stage load/store unit between the CPU pipeline and the word-only data RAM (256 x 32, asynchronous read, write on falling clock edge).
- Converts byte addresses to word indices.
- Performs byte/halfword stores as a two-cycle read-modify-write.
- Aligns and extends load data.
- Flags misaligned accesses instead of issuing them.
- Stalls the pipeline for one cycle during read-modify-write.

---
 rtl/mem_access_unit_if.sv | 34 +++
 rtl/mem_access_unit.sv | 144 ++++++++++++++
 tb/tb_mem_access_unit.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request, RAM and response bundle of the MEM-stage load/store unit
interface mem_access_unit_if;
  // pipeline request
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  // word RAM
  logic [31:0] ram_rdata;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_read;
  logic        ram_write;
  // pipeline response
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        misalign;
  logic [31:0] bad_addr;

  // environment side: pipeline plus RAM model
  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, ram_rdata,
    input  ram_addr, ram_wdata, ram_read, ram_write, stall, load_data, load_valid, misalign, bad_addr
  );

  // the load/store unit itself
  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, ram_rdata,
    output ram_addr, ram_wdata, ram_read, ram_write, stall, load_data, load_valid, misalign, bad_addr
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit with sub-word read-modify-write
module mem_access_unit #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic             clk,
  input  logic             rst,
  mem_access_unit_if.slave bus
);

  typedef enum logic {IDLE, RMW_WRITE} state_t;

  state_t                r_state;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [31:0]           r_merged;
  logic [31:0]           r_load_data;
  logic                  r_load_valid;
  logic                  r_misalign;
  logic [31:0]           r_bad_addr;

  logic                  w_misalign;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [31:0]           w_load_ext;
  logic [31:0]           w_merged;

  // Upper address bits are dropped so accesses wrap inside the RAM.
  assign w_idx = bus.req_addr[DEPTH_LOG2+1:2];

  // Alignment rules: reserved size, odd halfword, or word not on a 4-byte boundary.
  always_comb begin
    w_misalign = 1'b0;
    case (bus.req_size)
      2'b01:   w_misalign = bus.req_addr[0];
      2'b10:   w_misalign = (bus.req_addr[1:0] != 2'b00);
      2'b11:   w_misalign = 1'b1;
      default: w_misalign = 1'b0;
    endcase
  end

  // Pick the addressed lane out of the RAM word and sign/zero-extend it.
  always_comb begin
    w_byte     = 8'h00;
    w_half     = 16'h0000;
    w_load_ext = 32'h0000_0000;
    case (bus.req_addr[1:0])
      2'b00:   w_byte = bus.ram_rdata[7:0];
      2'b01:   w_byte = bus.ram_rdata[15:8];
      2'b10:   w_byte = bus.ram_rdata[23:16];
      default: w_byte = bus.ram_rdata[31:24];
    endcase
    w_half = bus.req_addr[1] ? bus.ram_rdata[31:16] : bus.ram_rdata[15:0];
    case (bus.req_size)
      2'b00:   w_load_ext = {{24{~bus.req_unsigned & w_byte[7]}}, w_byte};
      2'b01:   w_load_ext = {{16{~bus.req_unsigned & w_half[15]}}, w_half};
      default: w_load_ext = bus.ram_rdata;
    endcase
  end

  // Build the store word: current RAM contents with only the target lane replaced.
  always_comb begin
    w_merged = bus.ram_rdata;
    if (bus.req_size == 2'b00) begin
      case (bus.req_addr[1:0])
        2'b00:   w_merged[7:0]   = bus.req_wdata[7:0];
        2'b01:   w_merged[15:8]  = bus.req_wdata[7:0];
        2'b10:   w_merged[23:16] = bus.req_wdata[7:0];
        default: w_merged[31:24] = bus.req_wdata[7:0];
      endcase
    end else if (bus.req_addr[1]) begin
      w_merged[31:16] = bus.req_wdata[15:0];
    end else begin
      w_merged[15:0] = bus.req_wdata[15:0];
    end
  end

  // RAM strobes and stall decoded from state and request; everything low in reset
  // so a write in flight during RMW_WRITE is cut off immediately.
  always_comb begin
    bus.ram_read  = 1'b0;
    bus.ram_write = 1'b0;
    bus.ram_addr  = 32'h0000_0000;
    bus.ram_wdata = 32'h0000_0000;
    bus.stall     = 1'b0;
    if (!rst) begin
      if (r_state == RMW_WRITE) begin
        bus.ram_write = 1'b1;
        bus.ram_addr  = {{(32-DEPTH_LOG2){1'b0}}, r_idx};
        bus.ram_wdata = r_merged;
      end else if (bus.req_valid && !w_misalign) begin
        bus.ram_addr = {{(32-DEPTH_LOG2){1'b0}}, w_idx};
        if (!bus.req_write) begin
          bus.ram_read = 1'b1;
        end else if (bus.req_size == 2'b10) begin
          bus.ram_write = 1'b1;
          bus.ram_wdata = bus.req_wdata;
        end else begin
          bus.ram_read = 1'b1;
          bus.stall    = 1'b1;
        end
      end
    end
  end

  // Control FSM with the registered load/misalign responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_merged     <= 32'h0000_0000;
      r_load_data  <= 32'h0000_0000;
      r_load_valid <= 1'b0;
      r_misalign   <= 1'b0;
      r_bad_addr   <= 32'h0000_0000;
    end else begin
      r_load_valid <= 1'b0;
      r_misalign   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            if (w_misalign) begin
              r_misalign <= 1'b1;
              r_bad_addr <= bus.req_addr;
            end else if (!bus.req_write) begin
              r_load_data  <= w_load_ext;
              r_load_valid <= 1'b1;
            end else if (bus.req_size != 2'b10) begin
              r_idx    <= w_idx;
              r_merged <= w_merged;
              r_state  <= RMW_WRITE;
            end
          end
        end
        RMW_WRITE: r_state <= IDLE;
      endcase
    end
  end

  assign bus.load_data  = r_load_data;
  assign bus.load_valid = r_load_valid;
  assign bus.misalign   = r_misalign;
  assign bus.bad_addr   = r_bad_addr;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit against a byte-lane memory model
module tb_mem_access_unit;

  logic clk;
  logic rst;
  logic mem_clr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] ram     [256];
  logic [31:0] ref_mem [256];
  logic [31:0] exp_ld;
  logic [31:0] exp_bad;

  mem_access_unit_if ifc ();

  mem_access_unit #(.DEPTH_LOG2(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // word RAM: asynchronous read, write on the falling edge
  assign ifc.ram_rdata = ram[ifc.ram_addr[7:0]];
  always @(negedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
    end else if (ifc.ram_write) begin
      ram[ifc.ram_addr[7:0]] <= ifc.ram_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit is_misaligned(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a / 4) % 256);
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
    logic [31:0] v;
    int sh;
    v = ref_mem[word_of(a)];
    if (sz == 2'd0) begin
      sh = 8 * int'(a % 4);
      v = (v >> sh) & 32'hFF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      sh = 16 * int'((a / 2) % 2);
      v = (v >> sh) & 32'hFFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [1:0] sz,
                                              input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] mask;
    int sh;
    if (sz == 2'd0) begin
      sh = 8 * int'(a % 4);
      mask = 32'hFF << sh;
    end else begin
      sh = 16 * int'((a / 2) % 2);
      mask = 32'hFFFF << sh;
    end
    return (old & ~mask) | ((wd << sh) & mask);
  endfunction

  // One request from posedge+1 until its response is visible at a later posedge+1.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd);
    int idx;
    bit mis;
    bit sub;
    logic [31:0] merged;
    idx = word_of(a);
    mis = is_misaligned(sz, a);
    sub = wr && !mis && (sz != 2'd2);
    ifc.req_valid    = 1'b1;
    ifc.req_write    = wr;
    ifc.req_size     = sz;
    ifc.req_unsigned = uns;
    ifc.req_addr     = a;
    ifc.req_wdata    = wd;
    #1;
    check("ram_read",  {31'b0, ifc.ram_read},  {31'b0, !mis && (!wr || sub)});
    check("ram_write", {31'b0, ifc.ram_write}, {31'b0, !mis && wr && sz == 2'd2});
    check("stall",     {31'b0, ifc.stall},     {31'b0, sub});
    check("ram_addr",  ifc.ram_addr, mis ? 32'h0 : 32'(idx));
    if (!mis && wr && sz == 2'd2) check("ram_wdata", ifc.ram_wdata, wd);
    merged = model_merge(ref_mem[idx], sz, a, wd);
    if (sub) begin
      @(posedge clk); #1;
      // inputs are don't-care during the write-back cycle
      ifc.req_addr  = $urandom;
      ifc.req_size  = 2'($urandom_range(0, 3));
      ifc.req_write = 1'($urandom_range(0, 1));
      ifc.req_wdata = $urandom;
      #1;
      check("rmw_write", {31'b0, ifc.ram_write}, 32'd1);
      check("rmw_read",  {31'b0, ifc.ram_read},  32'd0);
      check("rmw_stall", {31'b0, ifc.stall},     32'd0);
      check("rmw_addr",  ifc.ram_addr, 32'(idx));
      check("rmw_wdata", ifc.ram_wdata, merged);
    end
    if (mis) exp_bad = a;
    else if (!wr) exp_ld = model_load(sz, uns, a);
    else ref_mem[idx] = (sz == 2'd2) ? wd : merged;
    @(posedge clk); #1;
    check("load_valid", {31'b0, ifc.load_valid}, {31'b0, !mis && !wr});
    check("misalign",   {31'b0, ifc.misalign},   {31'b0, mis});
    check("load_data",  ifc.load_data, exp_ld);
    check("bad_addr",   ifc.bad_addr, exp_bad);
    ifc.req_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    ifc.req_valid    = 1'b0;
    ifc.req_write    = 1'($urandom_range(0, 1));
    ifc.req_size     = 2'($urandom_range(0, 3));
    ifc.req_addr     = $urandom;
    ifc.req_wdata    = $urandom;
    #1;
    check("idle_strobes", {30'b0, ifc.ram_read, ifc.ram_write}, 32'd0);
    check("idle_stall",   {31'b0, ifc.stall}, 32'd0);
    check("idle_addr",    ifc.ram_addr, 32'd0);
    @(posedge clk); #1;
    check("idle_lv",  {30'b0, ifc.load_valid, ifc.misalign}, 32'd0);
    check("idle_ld",  ifc.load_data, exp_ld);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    rst = 1'b1;
    mem_clr = 1'b1;
    exp_ld = 32'h0;
    exp_bad = 32'h0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    ifc.req_valid = 1'b0; ifc.req_write = 1'b0; ifc.req_size = 2'd0;
    ifc.req_unsigned = 1'b0; ifc.req_addr = 32'h0; ifc.req_wdata = 32'h0;
    #2;
    check("rst_load_data",  ifc.load_data, 32'h0);
    check("rst_flags",      {30'b0, ifc.load_valid, ifc.misalign}, 32'd0);
    check("rst_bad_addr",   ifc.bad_addr, 32'h0);
    check("rst_strobes",    {29'b0, ifc.ram_read, ifc.ram_write, ifc.stall}, 32'd0);
    @(negedge clk); #1 mem_clr = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    // word store / load
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    check("word_load", ifc.load_data, 32'hDEAD_BEEF);
    // byte loads and a byte store
    do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h1122_3344);
    do_req(1'b0, 2'd0, 1'b0, 32'h23, 32'h0);
    check("sbyte_23", ifc.load_data, 32'h0000_0011);
    do_req(1'b1, 2'd0, 1'b0, 32'h21, 32'h0000_0080);
    do_req(1'b0, 2'd0, 1'b0, 32'h21, 32'h0);
    check("sbyte_21", ifc.load_data, 32'hFFFF_FF80);
    do_req(1'b0, 2'd0, 1'b1, 32'h21, 32'h0);
    check("ubyte_21", ifc.load_data, 32'h0000_0080);
    do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h1122_3344);
    do_req(1'b1, 2'd0, 1'b0, 32'h22, 32'hFFFF_FFAB);
    check("byte_merge", ram[8], 32'h11AB_3344);
    // halfword store and signed load
    do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h1122_3344);
    do_req(1'b1, 2'd1, 1'b0, 32'h22, 32'h1234_CAFE);
    check("half_merge", ram[8], 32'hCAFE_3344);
    do_req(1'b0, 2'd1, 1'b0, 32'h22, 32'h0);
    check("shalf_22", ifc.load_data, 32'hFFFF_CAFE);
    // misaligned requests
    do_req(1'b0, 2'd1, 1'b0, 32'h31, 32'h0);
    check("bad_31", ifc.bad_addr, 32'h31);
    do_req(1'b1, 2'd2, 1'b0, 32'h32, 32'h5555_5555);
    check("bad_32", ifc.bad_addr, 32'h32);
    do_req(1'b1, 2'd3, 1'b0, 32'h40, 32'h6666_6666);
    check("bad_40", ifc.bad_addr, 32'h40);
    check("mis_mem_0c", ram[12], 32'h0);
    check("mis_mem_10", ram[16], 32'h0);
    idle_cycle();

    // reset in the middle of a read-modify-write
    ifc.req_valid = 1'b1; ifc.req_write = 1'b1; ifc.req_size = 2'd0;
    ifc.req_unsigned = 1'b0; ifc.req_addr = 32'h10; ifc.req_wdata = 32'h5A;
    #1 check("rstrmw_stall", {31'b0, ifc.stall}, 32'd1);
    @(posedge clk); #1;
    check("rstrmw_write", {31'b0, ifc.ram_write}, 32'd1);
    rst = 1'b1;
    #1;
    check("rstrmw_drop",  {29'b0, ifc.ram_read, ifc.ram_write, ifc.stall}, 32'd0);
    check("rstrmw_addr",  ifc.ram_addr, 32'h0);
    check("rstrmw_ld",    ifc.load_data, 32'h0);
    check("rstrmw_bad",   ifc.bad_addr, 32'h0);
    check("rstrmw_flags", {30'b0, ifc.load_valid, ifc.misalign}, 32'd0);
    @(negedge clk); #1;
    check("rstrmw_mem", ram[4], 32'hDEAD_BEEF);
    ifc.req_valid = 1'b0;
    exp_ld = 32'h0;
    exp_bad = 32'h0;
    @(posedge clk); #1 rst = 1'b0;
    idle_cycle();
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    check("post_rst_load", ifc.load_data, 32'hDEAD_BEEF);

    // randomized traffic, addresses with random upper bits to exercise wrap
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        idle_cycle();
      end else begin
        sz = 2'($urandom_range(0, 3));
        a = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
        if ($urandom_range(0, 3) != 0) begin
          if (sz == 2'd1) a[0] = 1'b0;
          if (sz == 2'd2) a[1:0] = 2'b00;
        end
        do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
      end
    end

    for (int i = 0; i < 256; i++) check("final_mem", ram[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
